bp_cce_cfg_link_arbiter: RTL

- Shares one CCE config link among num_req_p requesters, e.g. the boot config loader and a debug/host config port.
- Round-robin grant per transaction; the grant is held while the link stalls.
- Forwards writes and reads; routes in-order read responses back to the issuing requester through a tag FIFO.
- Sits between config sources and the CCE config slave, zero added latency on the request path.

---
 rtl/bp_cce_pkg.sv | 27 ++
 rtl/bp_cce_cfg_tag_fifo.sv | 67 ++++++
 rtl/bp_cce_cfg_link_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bp_cce_pkg.sv
// Shared types and sizing helpers for the CCE config link arbiter.
`ifndef BP_CCE_PKG_SV
`define BP_CCE_PKG_SV

// Declares the per-requester config request struct at the caller's widths.
`define BP_CCE_DECLARE_CFG_REQ_S(addr_w, data_w) \
  typedef struct packed { \
    logic              w; \
    logic [addr_w-1:0] addr; \
    logic [data_w-1:0] data; \
  } bp_cce_cfg_req_s

package bp_cce_pkg;

  // Requester id width; a single bit even for one or two requesters.
  function automatic int bp_cce_req_id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Pointer width for a FIFO of the given depth, at least one bit.
  function automatic int bp_cce_ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`endif

// File: rtl/bp_cce_cfg_tag_fifo.sv
// In-order tag FIFO remembering which requester issued each outstanding read.
module bp_cce_cfg_tag_fifo
  import bp_cce_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_v_i,
  input  logic [width_p-1:0] push_data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] head_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = bp_cce_ptr_width(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  typedef logic [ptr_w_lp-1:0] ptr_t;
  typedef logic [cnt_w_lp-1:0] cnt_t;

  logic [els_p-1:0][width_p-1:0] mem_q, mem_d;
  ptr_t wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t cnt_q, cnt_d;
  logic push_ok, pop_ok;

  assign full_o  = (cnt_q == cnt_t'(els_p));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign push_ok = push_v_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next-state: write at wptr, read at rptr, both wrap at els_p-1.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) begin
      mem_d[wptr_q] = push_data_i;
      wptr_d = (wptr_q == ptr_t'(els_p - 1)) ? '0 : wptr_q + ptr_t'(1);
    end
    if (pop_ok) begin
      rptr_d = (rptr_q == ptr_t'(els_p - 1)) ? '0 : rptr_q + ptr_t'(1);
    end
    if (push_ok && !pop_ok)      cnt_d = cnt_q + cnt_t'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - cnt_t'(1);
  end

  // State registers; reset drops every outstanding tag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bp_cce_cfg_link_arbiter.sv
// Round-robin arbiter sharing one CCE config link among several requesters,
// holding the grant across link stalls and steering read data back by tag.
module bp_cce_cfg_link_arbiter
  import bp_cce_pkg::*;
#(
  parameter int num_req_p             = 2,
  parameter int cfg_link_addr_width_p = 16,
  parameter int cfg_link_data_width_p = 32,
  parameter int max_reads_p           = 4
) (
  input  logic                                              clk_i,
  input  logic                                              reset_n_i,
  input  logic [num_req_p*(cfg_link_addr_width_p-1)-1:0]    req_addr_i,
  input  logic [num_req_p*cfg_link_data_width_p-1:0]        req_data_i,
  input  logic [num_req_p-1:0]                              req_v_i,
  input  logic [num_req_p-1:0]                              req_w_i,
  output logic [num_req_p-1:0]                              req_ready_o,
  output logic [cfg_link_data_width_p-1:0]                  resp_data_o,
  output logic [num_req_p-1:0]                              resp_v_o,
  input  logic [num_req_p-1:0]                              resp_ready_i,
  output logic [cfg_link_addr_width_p-2:0]                  config_addr_o,
  output logic [cfg_link_data_width_p-1:0]                  config_data_o,
  output logic                                              config_v_o,
  output logic                                              config_w_o,
  input  logic                                              config_ready_i,
  input  logic [cfg_link_data_width_p-1:0]                  config_data_i,
  input  logic                                              config_v_i,
  output logic                                              config_ready_o
);

  localparam int addr_w_lp       = cfg_link_addr_width_p - 1;
  localparam int req_id_width_lp = bp_cce_req_id_width(num_req_p);

  `BP_CCE_DECLARE_CFG_REQ_S(addr_w_lp, cfg_link_data_width_p);
  typedef logic [req_id_width_lp-1:0] req_id_t;

  bp_cce_cfg_req_s [num_req_p-1:0] req_li;
  bp_cce_cfg_req_s                 sel;
  logic [num_req_p-1:0] elig;
  logic    fifo_full, fifo_empty, push, pop, head_ready;
  req_id_t head_id;
  req_id_t rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d;
  logic    lock_q, lock_d;
  req_id_t rr_gnt, gnt_id;
  logic    rr_found, lock_v, gnt_v, link_v, hs, stall;

  // Per-requester unpacking; reads wait while every tag slot is in use.
  for (genvar i = 0; i < num_req_p; i++) begin : g_lane
    assign req_li[i] = '{w:    req_w_i[i],
                         addr: req_addr_i[i*addr_w_lp +: addr_w_lp],
                         data: req_data_i[i*cfg_link_data_width_p +: cfg_link_data_width_p]};
    assign elig[i] = req_v_i[i] & (req_w_i[i] | ~fifo_full);
  end

  // Round-robin search: first eligible at or above rr_ptr, else first from 0.
  always_comb begin
    rr_gnt   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!rr_found && elig[i] && (i >= int'(rr_ptr_q))) begin
        rr_found = 1'b1;
        rr_gnt   = req_id_t'(i);
      end
    end
    for (int i = 0; i < num_req_p; i++) begin
      if (!rr_found && elig[i]) begin
        rr_found = 1'b1;
        rr_gnt   = req_id_t'(i);
      end
    end
  end

  // Grant selection and link mux; a stalled grantee keeps the link.
  always_comb begin
    lock_v = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (lock_id_q == req_id_t'(i)) lock_v = req_v_i[i];
    end
    gnt_id = lock_q ? lock_id_q : rr_gnt;
    gnt_v  = lock_q ? lock_v : rr_found;
    link_v = gnt_v & reset_n_i;
    sel    = '0;
    req_ready_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (link_v && (gnt_id == req_id_t'(i))) begin
        sel            = req_li[i];
        req_ready_o[i] = config_ready_i;
      end
    end
  end

  assign config_v_o    = link_v;
  assign config_w_o    = sel.w;
  assign config_addr_o = sel.addr;
  assign config_data_o = sel.data;
  assign hs            = link_v & config_ready_i;
  assign stall         = link_v & ~config_ready_i;
  assign push          = hs & ~sel.w;

  // Pointer advance on handshake, lock capture on stall.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (hs) begin
      rr_ptr_d = (gnt_id == req_id_t'(num_req_p - 1)) ? '0 : gnt_id + req_id_t'(1);
      lock_d   = 1'b0;
    end else if (stall) begin
      lock_d    = 1'b1;
      lock_id_d = gnt_id;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  bp_cce_cfg_tag_fifo #(
    .els_p   (max_reads_p),
    .width_p (req_id_width_lp)
  ) tag_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_v_i    (push),
    .push_data_i (gnt_id),
    .pop_i       (pop),
    .head_o      (head_id),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Route link read data to the oldest outstanding reader.
  always_comb begin
    resp_v_o   = '0;
    head_ready = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (head_id == req_id_t'(i)) begin
        head_ready  = resp_ready_i[i];
        resp_v_o[i] = config_v_i & ~fifo_empty;
      end
    end
  end

  assign resp_data_o    = reset_n_i ? config_data_i : '0;
  assign config_ready_o = ~fifo_empty & head_ready;
  assign pop            = config_v_i & config_ready_o;

`ifndef SYNTHESIS
  a_lock_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    lock_q |-> lock_v)
    else $error("locked requester dropped its request");
  a_resp_tagged: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    config_v_i |-> !fifo_empty)
    else $error("link read data with no outstanding read");
`endif

endmodule
